// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI target endpoint: opcodes, FSM states and
// the opcode decode helper used by the target FSM.
package qspi_pkg;

   localparam logic [7:0] QSPI_SLV_CMD_WR  = 8'h02;
   localparam logic [7:0] QSPI_SLV_CMD_RD  = 8'h03;
   localparam logic [7:0] QSPI_SLV_CMD_QWR = 8'h32;
   localparam logic [7:0] QSPI_SLV_CMD_QRD = 8'h6B;

   typedef enum logic [2:0] {
      QSPI_SLV_IDLE   = 3'd0,
      QSPI_SLV_CMD    = 3'd1,
      QSPI_SLV_DUMMY  = 3'd2,
      QSPI_SLV_WRITE  = 3'd3,
      QSPI_SLV_READ   = 3'd4,
      QSPI_SLV_IGNORE = 3'd5
   } qspi_slv_state_e;

   // State entered once the full opcode byte has been shifted in.
   function automatic qspi_slv_state_e qspi_slv_decode(input logic [7:0] op,
                                                       input logic       has_dummy);
      qspi_slv_state_e nxt;
      case (op)
         QSPI_SLV_CMD_WR,
         QSPI_SLV_CMD_QWR: nxt = QSPI_SLV_WRITE;
         QSPI_SLV_CMD_RD:  nxt = QSPI_SLV_READ;
         QSPI_SLV_CMD_QRD: nxt = has_dummy ? QSPI_SLV_DUMMY : QSPI_SLV_READ;
         default:          nxt = QSPI_SLV_IGNORE;
      endcase
      return nxt;
   endfunction

   // Opcodes whose payload travels on all four lanes.
   function automatic logic qspi_slv_is_quad(input logic [7:0] op);
      return (op == QSPI_SLV_CMD_QWR) || (op == QSPI_SLV_CMD_QRD);
   endfunction

endpackage

// File: rtl/udma_qspi_slave_sync.sv
// Brings the external master's SCK/CSN/SD lanes into the system clock domain
// through 2-flop synchronizers and produces one-cycle edge pulses. Lane data
// is delayed by the same amount as the edge pulses so that sdi_lvl is the
// value sampled together with the detected SCK edge.
module udma_qspi_slave_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       csn,
   input  logic [3:0] sdi,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       csn_rise,
   output logic       csn_fall,
   output logic       csn_lvl,
   output logic [3:0] sdi_lvl
);

   logic       sck_p0, sck_p1, sck_p2;
   logic       csn_p0, csn_p1, csn_p2;
   logic [3:0] sdi_p0, sdi_p1;

   // Synchronizer chain plus edge register; CSN idles high so no edge is
   // reported on reset release.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_p0   <= 1'b0;
         sck_p1   <= 1'b0;
         sck_p2   <= 1'b0;
         csn_p0   <= 1'b1;
         csn_p1   <= 1'b1;
         csn_p2   <= 1'b1;
         sdi_p0   <= 4'h0;
         sdi_p1   <= 4'h0;
         sdi_lvl  <= 4'h0;
         sck_rise <= 1'b0;
         sck_fall <= 1'b0;
         csn_rise <= 1'b0;
         csn_fall <= 1'b0;
      end else begin
         // stage p0 -> p1: metastability filter
         sck_p0   <= sck;
         csn_p0   <= csn;
         sdi_p0   <= sdi;
         sck_p1   <= sck_p0;
         csn_p1   <= csn_p0;
         sdi_p1   <= sdi_p0;
         // stage p1 -> p2: edge detect against the previous synchronized value
         sck_p2   <= sck_p1;
         csn_p2   <= csn_p1;
         sdi_lvl  <= sdi_p1;
         sck_rise <= sck_p1 & ~sck_p2;
         sck_fall <= ~sck_p1 & sck_p2;
         csn_rise <= csn_p1 & ~csn_p2;
         csn_fall <= ~csn_p1 & csn_p2;
      end
   end

   assign csn_lvl = csn_p2;

endmodule

// File: rtl/udma_qspi_slave.sv
// SPI/QSPI target endpoint. Decodes a one-byte opcode from the external
// master, streams write payload out as bytes and shifts read payload from a
// byte source back onto the pads. All SPI events are seen as synchronized
// edge pulses from udma_qspi_slave_sync.
module udma_qspi_slave
   import qspi_pkg::*;
#(
   parameter int unsigned DUMMY_CYCLES = 8
) (
   input  logic       sys_clk_i,
   input  logic       rst_i,
   input  logic       spi_sck_i,
   input  logic       spi_csn_i,
   input  logic [3:0] spi_sdi_i,
   output logic [3:0] spi_sdo_o,
   output logic [3:0] spi_oe_o,
   output logic [7:0] data_rx_o,
   output logic       data_rx_valid_o,
   input  logic       data_rx_ready_i,
   input  logic [7:0] data_tx_i,
   input  logic       data_tx_valid_i,
   output logic       data_tx_ready_o,
   input  logic       clr_i,
   output logic       overflow_o,
   output logic       underrun_o,
   output logic       eot_o,
   output logic       busy_o
);

   // Last dummy count before the read phase; only used when DUMMY_CYCLES > 0.
   localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
   localparam logic       HAS_DUMMY  = (DUMMY_CYCLES != 0);

   logic            sck_rise, sck_fall, csn_rise, csn_fall, csn_lvl;
   logic [3:0]      sdi_lvl;

   qspi_slv_state_e state_q;
   logic [2:0]      bit_cnt_q;
   logic [3:0]      dummy_cnt_q;
   logic            quad_q;
   logic [7:0]      rx_sr_q;
   logic [7:0]      tx_sr_q;
   logic [3:0]      sdo_q;
   logic [3:0]      oe_q;
   logic [7:0]      rx_data_q;
   logic            rx_vld_q;
   logic            tx_rdy_q;
   logic            eot_q;
   logic            ovf_q;
   logic            unr_q;

   logic [7:0]      cmd_byte;
   logic [7:0]      tx_byte;
   logic            load_evt;

   udma_qspi_slave_sync u_sync (
      .clk      (sys_clk_i),
      .rst      (rst_i),
      .sck      (spi_sck_i),
      .csn      (spi_csn_i),
      .sdi      (spi_sdi_i),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .csn_rise (csn_rise),
      .csn_fall (csn_fall),
      .csn_lvl  (csn_lvl),
      .sdi_lvl  (sdi_lvl)
   );

   // Opcode byte as it stands after the current sd0 bit is shifted in.
   assign cmd_byte = {rx_sr_q[6:0], sdi_lvl[0]};
   // A missing source byte is replaced by all ones on the wire.
   assign tx_byte  = data_tx_valid_i ? data_tx_i : 8'hFF;
   // Byte boundary in the read phase: the counter is zero on the first fall
   // after CMD/DUMMY and again after each complete byte.
   assign load_evt = (state_q == QSPI_SLV_READ) && sck_fall && !csn_rise &&
                     (bit_cnt_q == 3'd0);

   // Transfer FSM with its shift registers; CSN rise aborts from any state.
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q     <= QSPI_SLV_IDLE;
         bit_cnt_q   <= 3'd0;
         dummy_cnt_q <= 4'd0;
         quad_q      <= 1'b0;
         rx_sr_q     <= 8'h00;
         tx_sr_q     <= 8'h00;
         sdo_q       <= 4'h0;
         oe_q        <= 4'h0;
         rx_data_q   <= 8'h00;
         rx_vld_q    <= 1'b0;
         tx_rdy_q    <= 1'b0;
         eot_q       <= 1'b0;
      end else begin
         rx_vld_q <= 1'b0;
         tx_rdy_q <= 1'b0;
         eot_q    <= 1'b0;
         if (csn_rise) begin
            state_q <= QSPI_SLV_IDLE;
            oe_q    <= 4'h0;
            sdo_q   <= 4'h0;
            eot_q   <= (state_q != QSPI_SLV_IDLE);
         end else begin
            case (state_q)
               QSPI_SLV_IDLE: begin
                  if (csn_fall) begin
                     state_q   <= QSPI_SLV_CMD;
                     bit_cnt_q <= 3'd0;
                     rx_sr_q   <= 8'h00;
                  end
               end
               QSPI_SLV_CMD: begin
                  if (sck_rise) begin
                     rx_sr_q   <= cmd_byte;
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        state_q     <= qspi_slv_decode(cmd_byte, HAS_DUMMY);
                        quad_q      <= qspi_slv_is_quad(cmd_byte);
                        dummy_cnt_q <= 4'd0;
                     end
                  end
               end
               QSPI_SLV_DUMMY: begin
                  if (sck_rise) begin
                     dummy_cnt_q <= dummy_cnt_q + 4'd1;
                     if (dummy_cnt_q == DUMMY_LAST) begin
                        state_q <= QSPI_SLV_READ;
                     end
                  end
               end
               QSPI_SLV_WRITE: begin
                  if (sck_rise) begin
                     if (quad_q) begin
                        rx_sr_q   <= {rx_sr_q[3:0], sdi_lvl};
                        bit_cnt_q <= {2'b00, ~bit_cnt_q[0]};
                        if (bit_cnt_q[0]) begin
                           rx_data_q <= {rx_sr_q[3:0], sdi_lvl};
                           rx_vld_q  <= 1'b1;
                        end
                     end else begin
                        rx_sr_q   <= {rx_sr_q[6:0], sdi_lvl[0]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                           rx_data_q <= {rx_sr_q[6:0], sdi_lvl[0]};
                           rx_vld_q  <= 1'b1;
                        end
                     end
                  end
               end
               QSPI_SLV_READ: begin
                  if (sck_fall) begin
                     if (quad_q) begin
                        oe_q      <= 4'hF;
                        bit_cnt_q <= {2'b00, ~bit_cnt_q[0]};
                        if (load_evt) begin
                           sdo_q    <= tx_byte[7:4];
                           tx_sr_q  <= {tx_byte[3:0], 4'h0};
                           tx_rdy_q <= data_tx_valid_i;
                        end else begin
                           sdo_q    <= tx_sr_q[7:4];
                           tx_sr_q  <= {tx_sr_q[3:0], 4'h0};
                        end
                     end else begin
                        oe_q      <= 4'b0010;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (load_evt) begin
                           sdo_q    <= {2'b00, tx_byte[7], 1'b0};
                           tx_sr_q  <= {tx_byte[6:0], 1'b0};
                           tx_rdy_q <= data_tx_valid_i;
                        end else begin
                           sdo_q    <= {2'b00, tx_sr_q[7], 1'b0};
                           tx_sr_q  <= {tx_sr_q[6:0], 1'b0};
                        end
                     end
                  end
               end
               QSPI_SLV_IGNORE: begin
                  state_q <= QSPI_SLV_IGNORE;
               end
               default: begin
                  state_q <= QSPI_SLV_IDLE;
               end
            endcase
         end
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         unr_q <= 1'b0;
      end else begin
         if (rx_vld_q && !data_rx_ready_i) begin
            ovf_q <= 1'b1;
         end else if (clr_i) begin
            ovf_q <= 1'b0;
         end
         if (load_evt && !data_tx_valid_i) begin
            unr_q <= 1'b1;
         end else if (clr_i) begin
            unr_q <= 1'b0;
         end
      end
   end

   // Pads are released in the very cycle the CSN rise is detected.
   assign spi_oe_o        = csn_rise ? 4'h0 : oe_q;
   assign spi_sdo_o       = sdo_q;
   assign data_rx_o       = rx_data_q;
   assign data_rx_valid_o = rx_vld_q;
   assign data_tx_ready_o = tx_rdy_q;
   assign overflow_o      = ovf_q;
   assign underrun_o      = unr_q;
   assign eot_o           = eot_q;
   assign busy_o          = ~csn_lvl;

endmodule

// File: tb/tb_udma_qspi_slave.sv
// Bench for udma_qspi_slave: drives a behavioural SPI/QSPI master, supplies a
// byte source, collects the RX stream and compares against expectations
// from a table and from a transaction-level model.
module tb_udma_qspi_slave;

   localparam int DUMMY = 8;
   localparam int HALF  = 6;

   typedef struct {
      logic [7:0] op;
      logic [7:0] b0;
      logic [7:0] b1;
      logic       src;
      logic [1:0] mask;
      int         ab;
      logic [7:0] e0;
      logic [7:0] e1;
      int         e_acc;
      int         e_vld;
      int         e_rdy;
      logic [3:0] e_oe;
      logic       e_ovf;
      logic       e_unr;
      int         e_eot;
   } vec_t;

   logic       sys_clk = 1'b0;
   logic       rst     = 1'b1;
   logic       sck     = 1'b0;
   logic       csn     = 1'b1;
   logic [3:0] sdi     = 4'h0;
   logic       rx_rdy  = 1'b1;
   logic       clr     = 1'b0;
   logic [3:0] spi_sdo, spi_oe;
   logic [7:0] data_rx, data_tx;
   logic       data_rx_valid, data_tx_valid, data_tx_ready;
   logic       overflow, underrun, eot, busy;

   logic       src_en = 1'b0;
   logic [7:0] tx_b0  = 8'h00;
   logic [7:0] tx_b1  = 8'h00;
   int         tx_idx = 0;

   int         total = 0;
   int         bad   = 0;
   int         vld_cnt = 0, rdy_cnt = 0, eot_cnt = 0;
   logic       oe_eot_bad = 1'b0;
   logic [7:0] acc_q[$];

   always #5 sys_clk = ~sys_clk;

   udma_qspi_slave #(.DUMMY_CYCLES(DUMMY)) dut (
      .sys_clk_i       (sys_clk),
      .rst_i           (rst),
      .spi_sck_i       (sck),
      .spi_csn_i       (csn),
      .spi_sdi_i       (sdi),
      .spi_sdo_o       (spi_sdo),
      .spi_oe_o        (spi_oe),
      .data_rx_o       (data_rx),
      .data_rx_valid_o (data_rx_valid),
      .data_rx_ready_i (rx_rdy),
      .data_tx_i       (data_tx),
      .data_tx_valid_i (data_tx_valid),
      .data_tx_ready_o (data_tx_ready),
      .clr_i           (clr),
      .overflow_o      (overflow),
      .underrun_o      (underrun),
      .eot_o           (eot),
      .busy_o          (busy)
   );

   // Byte source: two bytes per transfer, advanced on each consume pulse.
   assign data_tx_valid = src_en && (tx_idx < 2);
   assign data_tx       = (tx_idx == 0) ? tx_b0 : tx_b1;

   // Stream monitor, sampled away from the active edge.
   always @(negedge sys_clk) begin
      if (data_rx_valid) begin
         vld_cnt++;
         if (rx_rdy) acc_q.push_back(data_rx);
      end
      if (data_tx_ready) begin
         rdy_cnt++;
         tx_idx++;
      end
      if (eot) begin
         eot_cnt++;
         if (spi_oe != 4'h0) oe_eot_bad = 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_clr();
      @(posedge sys_clk); #1 clr = 1'b1;
      @(posedge sys_clk); #1 clr = 1'b0;
   endtask

   // One SCK period: fall, drive lanes, sample pads just before the rise.
   task automatic sck_cycle(input logic [3:0] drv, output logic [3:0] sd,
                            output logic [3:0] oe);
      #1;
      sck = 1'b0;
      sdi = drv;
      repeat (HALF) @(posedge sys_clk);
      #1;
      sd  = spi_sdo;
      oe  = spi_oe;
      sck = 1'b1;
      repeat (HALF) @(posedge sys_clk);
   endtask

   // Transaction-level expectations from the opcode rules.
   function automatic vec_t model(input logic [7:0] op, input logic [7:0] b0,
                                  input logic [7:0] b1, input logic src,
                                  input logic [1:0] mask);
      vec_t       v;
      logic [7:0] q[$];
      logic       wr, rd, quad;
      wr   = (op == 8'h02) || (op == 8'h32);
      rd   = (op == 8'h03) || (op == 8'h6B);
      quad = (op == 8'h32) || (op == 8'h6B);
      v.op = op; v.b0 = b0; v.b1 = b1; v.src = src; v.mask = mask; v.ab = 0;
      if (wr) begin
         if (mask[0]) q.push_back(b0);
         if (mask[1]) q.push_back(b1);
      end
      if (rd) begin
         q.push_back(src ? b0 : 8'hFF);
         q.push_back(src ? b1 : 8'hFF);
      end
      v.e0    = (q.size() > 0) ? q[0] : 8'h00;
      v.e1    = (q.size() > 1) ? q[1] : 8'h00;
      v.e_acc = wr ? q.size() : 0;
      v.e_vld = wr ? 2 : 0;
      v.e_rdy = (rd && src) ? 2 : 0;
      v.e_oe  = !rd ? 4'h0 : (quad ? 4'hF : 4'h2);
      v.e_ovf = wr && (mask != 2'b11);
      v.e_unr = rd && !src;
      v.e_eot = 1;
      return v;
   endfunction

   // Runs one full transfer (or an aborted one when ab > 0) and checks it.
   task automatic apply(input vec_t v, input string tag);
      logic       quad, rd;
      logic [3:0] sd, oe, drv, oe_cmd, oe_or, oe_and;
      logic [7:0] g0, g1, bv;
      int         nclk, k, j;
      quad = (v.op == 8'h32) || (v.op == 8'h6B);
      rd   = (v.op == 8'h03) || (v.op == 8'h6B);
      pulse_clr();
      tx_b0 = v.b0; tx_b1 = v.b1; src_en = v.src; tx_idx = 0; rx_rdy = 1'b1;
      vld_cnt = 0; rdy_cnt = 0; eot_cnt = 0; acc_q.delete(); oe_eot_bad = 1'b0;
      oe_cmd = 4'h0; oe_or = 4'h0; oe_and = 4'hF; g0 = 8'h00; g1 = 8'h00;
      csn = 1'b0;
      repeat (HALF) @(posedge sys_clk);
      #1 check({tag, " busy_during"}, int'(busy), 1);
      for (int i = 7; i >= 0; i--) begin
         sck_cycle({3'b000, v.op[i]}, sd, oe);
         oe_cmd |= oe;
      end
      if (v.op == 8'h6B) begin
         for (int i = 0; i < DUMMY; i++) begin
            sck_cycle(4'h0, sd, oe);
            oe_cmd |= oe;
         end
      end
      nclk = (v.ab != 0) ? v.ab : (quad ? 4 : 16);
      for (int c = 0; c < nclk; c++) begin
         k      = quad ? c / 2 : c / 8;
         j      = quad ? c % 2 : c % 8;
         rx_rdy = v.mask[k];
         bv     = (k == 0) ? v.b0 : v.b1;
         drv    = quad ? ((j == 0) ? bv[7:4] : bv[3:0]) : {3'b000, bv[7-j]};
         sck_cycle(drv, sd, oe);
         if (k == 0) g0 = quad ? {g0[3:0], sd} : {g0[6:0], sd[1]};
         else        g1 = quad ? {g1[3:0], sd} : {g1[6:0], sd[1]};
         if (rd) begin
            oe_or  |= oe;
            oe_and &= oe;
         end else begin
            oe_cmd |= oe;
         end
      end
      #1 csn = 1'b1;
      repeat (12) @(posedge sys_clk);
      #1 sck = 1'b0;
      rx_rdy = 1'b1;
      repeat (HALF) @(posedge sys_clk);
      #1;
      check({tag, " oe_cmd"}, int'(oe_cmd), 0);
      if (rd) begin
         check({tag, " oe_data_or"}, int'(oe_or), int'(v.e_oe));
         check({tag, " oe_data_and"}, int'(oe_and), int'(v.e_oe));
         check({tag, " rd_byte0"}, int'(g0), int'(v.e0));
         if (v.ab == 0) check({tag, " rd_byte1"}, int'(g1), int'(v.e1));
      end
      check({tag, " rx_valid_cnt"}, vld_cnt, v.e_vld);
      check({tag, " tx_ready_cnt"}, rdy_cnt, v.e_rdy);
      check({tag, " rx_accepted"}, acc_q.size(), v.e_acc);
      for (int i = 0; i < acc_q.size() && i < v.e_acc; i++)
         check({tag, " rx_byte"}, int'(acc_q[i]), int'((i == 0) ? v.e0 : v.e1));
      check({tag, " eot_cnt"}, eot_cnt, v.e_eot);
      check({tag, " oe_at_eot"}, int'(oe_eot_bad), 0);
      check({tag, " overflow"}, int'(overflow), int'(v.e_ovf));
      check({tag, " underrun"}, int'(underrun), int'(v.e_unr));
      check({tag, " busy_after"}, int'(busy), 0);
      check({tag, " oe_after"}, int'(spi_oe), 0);
      if (v.e_ovf || v.e_unr) begin
         pulse_clr();
         #1;
         check({tag, " overflow_clr"}, int'(overflow), 0);
         check({tag, " underrun_clr"}, int'(underrun), 0);
      end
   endtask

   vec_t       tbl[6];
   logic [7:0] ops[4];

   initial begin
      logic [3:0] sd, oe;
      vec_t       v;

      tbl[0] = '{8'h02, 8'hA5, 8'h3C, 1'b0, 2'b11, 0, 8'hA5, 8'h3C, 2, 2, 0, 4'h0, 1'b0, 1'b0, 1};
      tbl[1] = '{8'h03, 8'h5A, 8'hC3, 1'b1, 2'b11, 0, 8'h5A, 8'hC3, 0, 0, 2, 4'h2, 1'b0, 1'b0, 1};
      tbl[2] = '{8'h6B, 8'hF0, 8'h96, 1'b1, 2'b11, 0, 8'hF0, 8'h96, 0, 0, 2, 4'hF, 1'b0, 1'b0, 1};
      tbl[3] = '{8'h32, 8'h12, 8'h34, 1'b0, 2'b01, 0, 8'h12, 8'h00, 1, 2, 0, 4'h0, 1'b1, 1'b0, 1};
      tbl[4] = '{8'h9F, 8'h55, 8'hAA, 1'b1, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 1'b0, 1'b0, 1};
      tbl[5] = '{8'h03, 8'h00, 8'h00, 1'b0, 2'b11, 5, 8'h1F, 8'h00, 0, 0, 0, 4'h2, 1'b0, 1'b1, 1};
      ops[0] = 8'h02; ops[1] = 8'h03; ops[2] = 8'h32; ops[3] = 8'h6B;

      // reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst sdo", int'(spi_sdo), 0);
      check("rst oe", int'(spi_oe), 0);
      check("rst rx_data", int'(data_rx), 0);
      check("rst pulses", int'({data_rx_valid, data_tx_ready, eot}), 0);
      check("rst flags", int'({overflow, underrun}), 0);
      check("rst busy", int'(busy), 0);
      rst = 1'b0;
      repeat (6) @(posedge sys_clk);

      for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 16; i++) begin
         v = model(ops[$urandom_range(0, 3)], 8'($urandom), 8'($urandom),
                   1'($urandom), 2'($urandom));
         apply(v, $sformatf("rnd%0d", i));
      end

      // reset in the middle of a read that has already underrun
      pulse_clr();
      src_en = 1'b0; tx_idx = 0;
      csn = 1'b0;
      repeat (HALF) @(posedge sys_clk);
      for (int i = 7; i >= 0; i--) sck_cycle({3'b000, ops[1][i]}, sd, oe);
      for (int i = 0; i < 3; i++) sck_cycle(4'h0, sd, oe);
      check("midrst oe_before", int'(oe), 2);
      #1 check("midrst unr_before", int'(underrun), 1);
      @(posedge sys_clk);
      #1 rst = 1'b1;
      @(posedge sys_clk);
      #1;
      check("midrst sdo", int'(spi_sdo), 0);
      check("midrst oe", int'(spi_oe), 0);
      check("midrst rx_data", int'(data_rx), 0);
      check("midrst pulses", int'({data_rx_valid, data_tx_ready, eot}), 0);
      check("midrst flags", int'({overflow, underrun}), 0);
      check("midrst busy", int'(busy), 0);
      csn = 1'b1;
      sck = 1'b0;
      repeat (8) @(posedge sys_clk);
      #1 rst = 1'b0;
      repeat (8) @(posedge sys_clk);
      #1;
      check("postrst busy", int'(busy), 0);
      check("postrst oe", int'(spi_oe), 0);

      // endpoint still works after the mid-transfer reset
      apply(tbl[1], "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
